// File: rtl/can_clic_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : can_clic_ctrl_if
// Purpose  : Configuration bus and interrupt offer/return handshake between
//            the core and the CLIC controller.
// Revision : 1.0
// ============================================================================
interface can_clic_ctrl_if #(
    parameter int PRIO_BITS  = 3,
    parameter int INDEX_BITS = 2
);
    logic                  cfg_we;
    logic [INDEX_BITS-1:0] cfg_idx;
    logic                  cfg_enable;
    logic [PRIO_BITS-1:0]  cfg_prio;
    logic                  irq_valid;
    logic                  irq_ready;
    logic [INDEX_BITS-1:0] irq_id;
    logic [PRIO_BITS-1:0]  irq_prio;
    logic                  complete;

    // master is the core side, slave is the controller
    modport master (
        output cfg_we, cfg_idx, cfg_enable, cfg_prio, irq_ready, complete,
        input  irq_valid, irq_id, irq_prio
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_enable, cfg_prio, irq_ready, complete,
        output irq_valid, irq_id, irq_prio
    );
endinterface
`default_nettype wire

// File: rtl/can_clic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : can_clic_ctrl
// Purpose  : Sequential CLIC controller: edge-detected pending state, bit-serial
//            MSB-first priority elimination, valid/ready offer and nesting stack.
// Revision : 1.0
// ============================================================================
module can_clic_ctrl #(
    parameter int PRIO_BITS  = 3,
    parameter int INDEX_BITS = 2,
    parameter int NEST_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2**INDEX_BITS-1:0] irq_src,
    can_clic_ctrl_if.slave           bus,
    output logic [PRIO_BITS-1:0]     cur_level,
    output logic                     nest_full,
    output logic                     err_underflow
);
    localparam int c_NUM_IRQ = 2**INDEX_BITS;
    localparam int c_SP_W    = $clog2(NEST_DEPTH + 1);
    localparam int c_SI_W    = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam int c_J_W     = (PRIO_BITS > 1) ? $clog2(PRIO_BITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_OFFER = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [c_NUM_IRQ-1:0]  r_src_q;
    logic [c_NUM_IRQ-1:0]  r_pending;
    logic [c_NUM_IRQ-1:0]  r_enable;
    logic [PRIO_BITS-1:0]  r_prio [c_NUM_IRQ];
    logic [c_NUM_IRQ-1:0]  r_contender;
    logic [c_J_W-1:0]      r_j;

    logic [PRIO_BITS-1:0]  r_stack [NEST_DEPTH];
    logic [c_SP_W-1:0]     r_sp;
    logic [PRIO_BITS-1:0]  r_cur_level;
    logic                  r_err;

    logic                  r_valid;
    logic [INDEX_BITS-1:0] r_id;
    logic [PRIO_BITS-1:0]  r_irq_prio;

    logic [c_NUM_IRQ-1:0]  w_rise;
    logic [c_NUM_IRQ-1:0]  w_eligible;
    logic [c_NUM_IRQ-1:0]  w_bit_j;
    logic [c_NUM_IRQ-1:0]  w_survivors;
    logic [c_NUM_IRQ-1:0]  w_clr;
    logic [INDEX_BITS-1:0] w_win_id;
    logic [PRIO_BITS-1:0]  w_win_prio;
    logic                  w_nest_full;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_offer_load;
    logic [c_SI_W-1:0]     w_push_idx;
    logic [c_SI_W-1:0]     w_top_idx;

    assign w_rise = irq_src & ~r_src_q;

    for (genvar gi = 0; gi < c_NUM_IRQ; gi++) begin : g_src
        assign w_eligible[gi] = r_pending[gi] & r_enable[gi] & (r_prio[gi] > r_cur_level);
        assign w_bit_j[gi]    = r_prio[gi][r_j];
    end

    // Only eliminate on this bit when at least one contender carries a 1 there
    assign w_survivors = (|(r_contender & w_bit_j)) ? (r_contender & w_bit_j) : r_contender;

    always_comb begin
        w_win_id = '0;
        for (int i = c_NUM_IRQ - 1; i >= 0; i--) begin
            if (w_survivors[i]) begin
                w_win_id = INDEX_BITS'(i);
            end
        end
    end

    assign w_win_prio  = r_prio[w_win_id];
    assign w_nest_full = (r_sp == c_SP_W'(NEST_DEPTH));
    assign w_push_idx  = r_sp[c_SI_W-1:0];
    assign w_top_idx   = c_SI_W'(r_sp - 1'b1);

    // A simultaneous complete takes precedence and leaves the offer standing
    assign w_accept = (r_state == S_OFFER) & r_valid & bus.irq_ready & ~bus.complete;

    always_comb begin
        w_clr = '0;
        if (w_accept) begin
            w_clr[r_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_offer_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((|w_eligible) && !w_nest_full && !bus.cfg_we) begin
                    w_start      = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (bus.cfg_we) begin
                    w_state_next = S_IDLE;
                end else if (r_j == '0) begin
                    w_offer_load = 1'b1;
                    w_state_next = S_OFFER;
                end
            end
            S_OFFER: begin
                if (w_accept) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_q     <= '0;
            r_pending   <= '0;
            r_enable    <= '0;
            r_contender <= '0;
            r_j         <= '0;
            r_sp        <= '0;
            r_cur_level <= '0;
            r_err       <= 1'b0;
            r_valid     <= 1'b0;
            r_id        <= '0;
            r_irq_prio  <= '0;
            for (int k = 0; k < c_NUM_IRQ; k++) begin
                r_prio[k] <= '0;
            end
            for (int k = 0; k < NEST_DEPTH; k++) begin
                r_stack[k] <= '0;
            end
        end else begin
            r_src_q   <= irq_src;
            r_pending <= (r_pending & ~w_clr) | w_rise;

            if (bus.cfg_we) begin
                r_enable[bus.cfg_idx] <= bus.cfg_enable;
                r_prio[bus.cfg_idx]   <= bus.cfg_prio;
            end

            if (w_start) begin
                r_contender <= w_eligible;
                r_j         <= c_J_W'(PRIO_BITS - 1);
            end else if (r_state == S_SCAN) begin
                r_contender <= w_survivors;
                r_j         <= r_j - 1'b1;
            end

            if (w_offer_load) begin
                r_valid    <= 1'b1;
                r_id       <= w_win_id;
                r_irq_prio <= w_win_prio;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            // Scans only start below full depth, so an accept always has room
            if (w_accept) begin
                r_stack[w_push_idx] <= r_cur_level;
                r_sp                <= r_sp + 1'b1;
                r_cur_level         <= r_irq_prio;
            end else if (bus.complete) begin
                if (r_sp != '0) begin
                    r_cur_level <= r_stack[w_top_idx];
                    r_sp        <= r_sp - 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.irq_valid = r_valid;
    assign bus.irq_id    = r_id;
    assign bus.irq_prio  = r_irq_prio;
    assign cur_level     = r_cur_level;
    assign nest_full     = w_nest_full;
    assign err_underflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_can_clic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_clic_ctrl
// Purpose  : Directed self-checking bench with an offer scoreboard.
// Revision : 1.0
// ============================================================================
module tb_can_clic_ctrl;
    localparam int PB = 3;
    localparam int IB = 2;
    localparam int ND = 4;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq_src = '0;
    logic [PB-1:0] cur_level;
    logic          nest_full;
    logic          err_underflow;

    can_clic_ctrl_if #(.PRIO_BITS(PB), .INDEX_BITS(IB)) bus ();

    can_clic_ctrl #(.PRIO_BITS(PB), .INDEX_BITS(IB), .NEST_DEPTH(ND)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_src       (irq_src),
        .bus           (bus),
        .cur_level     (cur_level),
        .nest_full     (nest_full),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IB-1:0] id;
        logic [PB-1:0] prio;
    } offer_t;

    offer_t sb[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int idx, input logic en, input int prio);
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = IB'(idx);
        bus.cfg_enable = en;
        bus.cfg_prio   = PB'(prio);
        @(negedge clk);
        bus.cfg_we     = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        irq_src = mask;
        @(negedge clk);
        irq_src = '0;
    endtask

    task automatic accept();
        bus.irq_ready = 1'b1;
        @(negedge clk);
        bus.irq_ready = 1'b0;
    endtask

    task automatic done();
        bus.complete = 1'b1;
        @(negedge clk);
        bus.complete = 1'b0;
    endtask

    task automatic expect_offer(input int id, input int prio);
        offer_t e;
        e.id   = IB'(id);
        e.prio = PB'(prio);
        sb.push_back(e);
    endtask

    task automatic wait_offer(input string tag);
        offer_t e;
        int     n;
        n = 0;
        while (bus.irq_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " valid"}, bus.irq_valid, 1);
        chk({tag, " queued"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " id"}, bus.irq_id, e.id);
            chk({tag, " prio"}, bus.irq_prio, e.prio);
        end
    endtask

    task automatic quiet(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.irq_valid === 1'b1) seen = 1'b1;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        bus.cfg_we     = 1'b0;
        bus.cfg_idx    = '0;
        bus.cfg_enable = 1'b0;
        bus.cfg_prio   = '0;
        bus.irq_ready  = 1'b0;
        bus.complete   = 1'b0;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;

        chk("rst valid", bus.irq_valid, 0);
        chk("rst id", bus.irq_id, 0);
        chk("rst prio", bus.irq_prio, 0);
        chk("rst level", cur_level, 0);
        chk("rst full", nest_full, 0);
        chk("rst err", err_underflow, 0);

        // Single source and exact offer latency
        cfg(2, 1'b1, 5);
        expect_offer(2, 5);
        pulse(4'b0100);
        tick(3);
        chk("t1 early", bus.irq_valid, 0);
        tick(1);
        chk("t1 latency", bus.irq_valid, 1);
        wait_offer("t1");
        accept();
        chk("t1 valid drop", bus.irq_valid, 0);
        chk("t1 level", cur_level, 5);
        done();
        chk("t1 pop", cur_level, 0);
        quiet(8, "t1 no reoffer");

        // Elimination with tie-break on lower index
        cfg(0, 1'b1, 3);
        cfg(1, 1'b1, 6);
        cfg(2, 1'b1, 6);
        cfg(3, 1'b1, 2);
        expect_offer(1, 6);
        pulse(4'b1111);
        wait_offer("t2 first");
        accept();
        chk("t2 level", cur_level, 6);
        quiet(6, "t2 masked");
        done();
        chk("t2 pop", cur_level, 0);
        expect_offer(2, 6);
        wait_offer("t2 second");
        accept();
        done();
        expect_offer(0, 3);
        wait_offer("t2 third");
        accept();
        done();
        expect_offer(3, 2);
        wait_offer("t2 fourth");
        accept();
        chk("t2 level4", cur_level, 2);
        done();
        chk("t2 final", cur_level, 0);

        // Preemption and nesting
        cfg(0, 1'b1, 4);
        cfg(2, 1'b1, 4);
        cfg(1, 1'b1, 7);
        expect_offer(0, 4);
        pulse(4'b0001);
        wait_offer("t3 base");
        accept();
        chk("t3 level4", cur_level, 4);
        pulse(4'b0100);
        quiet(8, "t3 equal prio");
        expect_offer(1, 7);
        pulse(4'b0010);
        wait_offer("t3 preempt");
        accept();
        chk("t3 level7", cur_level, 7);
        done();
        chk("t3 back4", cur_level, 4);
        quiet(6, "t3 still masked");
        done();
        chk("t3 back0", cur_level, 0);
        expect_offer(2, 4);
        wait_offer("t3 deferred");
        accept();
        chk("t3 deferred level", cur_level, 4);
        done();
        chk("t3 end", cur_level, 0);

        // Stack depth limit and underflow
        cfg(0, 1'b1, 1);
        cfg(1, 1'b1, 2);
        cfg(2, 1'b1, 3);
        cfg(3, 1'b1, 4);
        for (int k = 0; k < ND; k++) begin
            expect_offer(k, k + 1);
            pulse(N'(1 << k));
            wait_offer("t4 fill");
            accept();
            chk("t4 fill level", cur_level, k + 1);
        end
        chk("t4 full", nest_full, 1);
        cfg(0, 1'b1, 7);
        pulse(4'b0001);
        quiet(8, "t4 full blocks");
        expect_offer(0, 7);
        done();
        chk("t4 pop level", cur_level, 3);
        chk("t4 not full", nest_full, 0);
        wait_offer("t4 after pop");
        accept();
        chk("t4 level7", cur_level, 7);
        for (int k = 3; k >= 0; k--) begin
            done();
            chk("t4 unwind", cur_level, k);
        end
        chk("t4 err before", err_underflow, 0);
        done();
        chk("t4 underflow", err_underflow, 1);
        chk("t4 underflow level", cur_level, 0);

        // cfg write during scan aborts; ready together with complete
        cfg(1, 1'b1, 5);
        expect_offer(3, 4);
        pulse(4'b1000);
        wait_offer("t5 base");
        accept();
        chk("t5 level4", cur_level, 4);
        expect_offer(1, 6);
        pulse(4'b0010);
        tick(1);
        cfg(1, 1'b1, 6);
        tick(2);
        chk("t5 aborted", bus.irq_valid, 0);
        wait_offer("t5 new prio");
        bus.irq_ready = 1'b1;
        bus.complete  = 1'b1;
        @(negedge clk);
        bus.irq_ready = 1'b0;
        bus.complete  = 1'b0;
        chk("t5 rdy+cpl level", cur_level, 0);
        chk("t5 rdy+cpl valid", bus.irq_valid, 1);
        chk("t5 rdy+cpl id", bus.irq_id, 1);
        accept();
        chk("t5 level6", cur_level, 6);
        done();
        chk("t5 end", cur_level, 0);
        chk("t5 err sticky", err_underflow, 1);

        // Asynchronous reset while an offer is standing
        expect_offer(0, 7);
        pulse(4'b0111);
        wait_offer("t6 offer");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async valid", bus.irq_valid, 0);
        chk("t6 async err", err_underflow, 0);
        tick(2);
        rst_n = 1'b1;
        chk("t6 level", cur_level, 0);
        cfg(0, 1'b1, 7);
        cfg(1, 1'b1, 6);
        cfg(2, 1'b1, 3);
        quiet(10, "t6 pending cleared");
        chk("t6 sb drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
